// File: rtl/jtag_host_seq.sv
// -----------------------------------------------------------------------------
// jtag_host_seq
//
// Command-driven JTAG host. Each accepted command moves the target TAP from
// Run-Test/Idle through an IR or DR scan (or idle clocking, or a TAP reset)
// and back to Run-Test/Idle. The captured TDO bits are then returned as a
// single response.
//
// Parameters
//   CLK_DIV  clk cycles per TCK half-period (>= 1)
//   MAX_LEN  widest shift in bits (cmd_len is clamped to it, and to 63)
//
// Ports
//   clk, rst_n            system clock, asynchronous active-low reset
//   cmd_valid/cmd_ready   command handshake; cmd_ready only in IDLE
//   cmd_op                00 SHIFT_IR, 01 SHIFT_DR, 10 TLR, 11 RUN_IDLE
//   cmd_len               shift length (IR/DR) or TCK count (RUN_IDLE)
//   cmd_data              TDI bits, LSB first
//   rsp_valid/rsp_ready   response handshake; rsp_data held until consumed
//   rsp_data              captured TDO bits, right-aligned, upper bits zero
//   TCK, TMS, TDI, TDO    JTAG pins
//   busy                  high from acceptance until rsp_valid
//
// Build option
//   JTAG_HOST_TLR_EN  when defined, TLR clocks 5x TMS=1 and then 1x TMS=0.
//                     Otherwise TLR completes at once with no TCK pulses.
//
// Each command is split into three pulse segments: HEAD, SHIFT and TAIL.
// Segments of zero length are skipped. RUN_IDLE and TLR use the HEAD segment
// only. A command with no pulses at all stays in HEAD for one clk and then
// responds.
// -----------------------------------------------------------------------------
module jtag_host_seq #(
    parameter int CLK_DIV = 4,
    parameter int MAX_LEN = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [5:0]         cmd_len,
    input  logic [MAX_LEN-1:0] cmd_data,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [MAX_LEN-1:0] rsp_data,
    output logic               TCK,
    output logic               TMS,
    output logic               TDI,
    input  logic               TDO,
    output logic               busy
);

    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int LEN_CAP = (MAX_LEN < 63) ? MAX_LEN : 63;

    localparam logic [1:0] OP_IR  = 2'b00;
    localparam logic [1:0] OP_DR  = 2'b01;
    localparam logic [1:0] OP_TLR = 2'b10;
    localparam logic [1:0] OP_RTI = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HEAD,
        S_SHIFT,
        S_TAIL,
        S_RESP
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         op_q, op_d;
    logic [MAX_LEN-1:0] data_q, data_d;
    logic [5:0]         head_len_q, head_len_d;
    logic [5:0]         shift_len_q, shift_len_d;
    logic [5:0]         tail_len_q, tail_len_d;
    logic [5:0]         idx_q, idx_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic               tck_q, tck_d;
    logic               tms_q, tms_d;
    logic               tdi_q, tdi_d;
    logic [MAX_LEN-1:0] rsp_q, rsp_d;
    logic               rst_done_q;

    logic               accept;
    logic               pulsing;
    logic               half_end;
    logic               pulse_end;
    logic               zero_cmd;
    logic [5:0]         cur_len;
    logic               seg_last;
    logic [5:0]         len_c;
    logic [MAX_LEN-1:0] tdi_sel;
    logic [MAX_LEN-1:0] cap_sel;

    // One-hot bit selects: tdi_sel picks the TDI bit for the pulse about to
    // start, and cap_sel picks the response bit for the pulse in progress.
    for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_sel
        assign tdi_sel[gi] = (idx_d == 6'(gi));
        assign cap_sel[gi] = (idx_q == 6'(gi));
    end

    assign accept    = cmd_valid && cmd_ready;
    assign pulsing   = (state_q == S_HEAD) || (state_q == S_SHIFT) || (state_q == S_TAIL);
    assign half_end  = (div_q == DIV_W'(CLK_DIV - 1));
    assign zero_cmd  = (state_q == S_HEAD) && (head_len_q == 6'd0);
    assign pulse_end = pulsing && !zero_cmd && tck_q && half_end;
    assign len_c     = (int'(cmd_len) > LEN_CAP) ? 6'(LEN_CAP) : cmd_len;

    always_comb begin
        cur_len = head_len_q;
        case (state_q)
            S_SHIFT: cur_len = shift_len_q;
            S_TAIL:  cur_len = tail_len_q;
            default: cur_len = head_len_q;
        endcase
    end
    assign seg_last = ((idx_q + 6'd1) == cur_len);

    // State register together with all other flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            op_q        <= 2'b00;
            data_q      <= '0;
            head_len_q  <= 6'd0;
            shift_len_q <= 6'd0;
            tail_len_q  <= 6'd0;
            idx_q       <= 6'd0;
            div_q       <= '0;
            tck_q       <= 1'b0;
            tms_q       <= 1'b1;
            tdi_q       <= 1'b0;
            rsp_q       <= '0;
            rst_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            data_q      <= data_d;
            head_len_q  <= head_len_d;
            shift_len_q <= shift_len_d;
            tail_len_q  <= tail_len_d;
            idx_q       <= idx_d;
            div_q       <= div_d;
            tck_q       <= tck_d;
            tms_q       <= tms_d;
            tdi_q       <= tdi_d;
            rsp_q       <= rsp_d;
            rst_done_q  <= 1'b1;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_HEAD;
            S_HEAD: begin
                if (zero_cmd) begin
                    state_d = S_RESP;
                end else if (pulse_end && seg_last) begin
                    if (shift_len_q != 6'd0)     state_d = S_SHIFT;
                    else if (tail_len_q != 6'd0) state_d = S_TAIL;
                    else                         state_d = S_RESP;
                end
            end
            S_SHIFT: if (pulse_end && seg_last) state_d = (tail_len_q != 6'd0) ? S_TAIL : S_RESP;
            S_TAIL:  if (pulse_end && seg_last) state_d = S_RESP;
            S_RESP:  if (rsp_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs that depend on the FSM state. cmd_ready waits for the first
    // clk edge after reset release.
    always_comb begin
        cmd_ready = (state_q == S_IDLE) && rst_done_q;
        rsp_valid = (state_q == S_RESP);
        busy      = pulsing;
    end

    // Datapath: command latch, TCK divider, segment index and TDO capture.
    always_comb begin
        op_d        = op_q;
        data_d      = data_q;
        head_len_d  = head_len_q;
        shift_len_d = shift_len_q;
        tail_len_d  = tail_len_q;
        idx_d       = idx_q;
        div_d       = div_q;
        tck_d       = tck_q;
        rsp_d       = rsp_q;

        if (accept) begin
            op_d        = cmd_op;
            data_d      = cmd_data;
            head_len_d  = 6'd0;
            shift_len_d = 6'd0;
            tail_len_d  = 6'd0;
            case (cmd_op)
                OP_IR: if (len_c != 6'd0) begin
                    head_len_d  = 6'd4;
                    shift_len_d = len_c;
                    tail_len_d  = 6'd2;
                end
                OP_DR: if (len_c != 6'd0) begin
                    head_len_d  = 6'd3;
                    shift_len_d = len_c;
                    tail_len_d  = 6'd2;
                end
`ifdef JTAG_HOST_TLR_EN
                OP_TLR: head_len_d = 6'd6;
`else
                OP_TLR: head_len_d = 6'd0;
`endif
                OP_RTI: head_len_d = len_c;
                default: head_len_d = 6'd0;
            endcase
            idx_d = 6'd0;
            div_d = '0;
            tck_d = 1'b0;
            rsp_d = '0;
        end else if (pulsing && !zero_cmd) begin
            if (half_end) begin
                div_d = '0;
                tck_d = !tck_q;
                if (pulse_end) idx_d = seg_last ? 6'd0 : idx_q + 6'd1;
            end else begin
                div_d = div_q + DIV_W'(1);
            end
            // TDO is taken in the first clk cycle that TCK is high.
            if ((state_q == S_SHIFT) && tck_q && (div_q == '0) && TDO)
                rsp_d = rsp_q | cap_sel;
        end
        if (!pulsing) tck_d = 1'b0;
    end

    // TMS/TDI are computed for the next pulse. They can only change at the
    // edge where that pulse starts, and TCK is low from that edge onward.
    always_comb begin
        tms_d = tms_q;
        tdi_d = 1'b0;
        case (state_d)
            S_HEAD: begin
                case (op_d)
                    OP_IR:   tms_d = (idx_d < 6'd2);
                    OP_DR:   tms_d = (idx_d == 6'd0);
                    OP_TLR:  tms_d = (idx_d < 6'd5);
                    default: tms_d = 1'b0;
                endcase
            end
            S_SHIFT: begin
                tms_d = ((idx_d + 6'd1) == shift_len_q);
                tdi_d = |(data_q & tdi_sel);
            end
            S_TAIL:  tms_d = (idx_d == 6'd0);
            default: tms_d = tms_q;
        endcase
    end

    assign TCK      = tck_q;
    assign TMS      = tms_q;
    assign TDI      = tdi_q;
    assign rsp_data = rsp_q;

endmodule

// File: tb/tb_jtag_host_seq.sv
// -----------------------------------------------------------------------------
// tb_jtag_host_seq
//
// Bench for jtag_host_seq with CLK_DIV=2 and MAX_LEN=32. A table of commands
// is applied one at a time. The expected response, latency and TMS/TDI pulse
// patterns are pushed to a scoreboard when a command is driven, and they are
// popped when rsp_valid appears. TDO is looped back from TDI, inverted, or
// tied to a constant. Hand-written sequences cover reset, an abort in the
// middle of a shift, and response back-pressure.
// -----------------------------------------------------------------------------
module tb_jtag_host_seq;

    localparam int CLK_DIV = 2;
    localparam int MAX_LEN = 32;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               cmd_valid;
    logic               cmd_ready;
    logic [1:0]         cmd_op;
    logic [5:0]         cmd_len;
    logic [MAX_LEN-1:0] cmd_data;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [MAX_LEN-1:0] rsp_data;
    logic               TCK, TMS, TDI, TDO;
    logic               busy;

    int tdo_mode = 0;  // 0 loopback, 1 const one, 2 const zero, 3 inverted loopback

    jtag_host_seq #(.CLK_DIV(CLK_DIV), .MAX_LEN(MAX_LEN)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_len   (cmd_len),
        .cmd_data  (cmd_data),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .TCK       (TCK),
        .TMS       (TMS),
        .TDI       (TDI),
        .TDO       (TDO),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    assign TDO = (tdo_mode == 0) ? TDI :
                 (tdo_mode == 1) ? 1'b1 :
                 (tdo_mode == 2) ? 1'b0 : ~TDI;

    // ---------------- pin monitor ----------------
    bit   tms_log[$];
    bit   tdi_log[$];
    logic prev_tck = 1'b0, prev_tms = 1'b1, prev_tdi = 1'b0;
    int   hi_run = 0;
    int   viol = 0;
    bit   aborted = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            aborted <= 1'b1;
            hi_run  <= 0;
        end else if (TCK) begin
            if (!prev_tck) begin
                tms_log.push_back(TMS);
                tdi_log.push_back(TDI);
                hi_run  <= 1;
                aborted <= 1'b0;
            end else begin
                hi_run <= hi_run + 1;
            end
            if (TMS != prev_tms || TDI != prev_tdi) viol <= viol + 1;
        end else if (prev_tck && !aborted && hi_run != CLK_DIV) begin
            viol <= viol + 1;
        end
        prev_tck <= TCK;
        prev_tms <= TMS;
        prev_tdi <= TDI;
    end

    // ---------------- checking helpers ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [5:0]  len;
        logic [31:0] data;
        int          mode;
        int          delay;
        logic [31:0] exp_rsp;
        int          exp_pulses;
    } vec_t;

    typedef struct {
        logic [31:0] rsp;
        int          pulses;
        int          lat;
        logic [63:0] tms;
        logic [63:0] tdi;
    } exp_t;

    exp_t sb[$];

    // Reference pulse pattern for one command, built pulse by pulse.
    function automatic void model(input logic [1:0] op, input logic [5:0] len,
                                  input logic [31:0] data,
                                  output logic [63:0] tms, output logic [63:0] tdi,
                                  output int p);
        int eff;
        eff = (int'(len) > MAX_LEN) ? MAX_LEN : int'(len);
        tms = '0;
        tdi = '0;
        p   = 0;
        case (op)
            2'b00, 2'b01: if (eff > 0) begin
                tms[0] = 1'b1;
                if (op == 2'b00) begin
                    tms[1] = 1'b1;
                    p = 4;
                end else begin
                    p = 3;
                end
                for (int i = 0; i < eff; i++) begin
                    tdi[p] = data[i];
                    tms[p] = (i == eff - 1);
                    p++;
                end
                tms[p] = 1'b1;
                p = p + 2;
            end
            2'b10: begin
`ifdef JTAG_HOST_TLR_EN
                for (int i = 0; i < 5; i++) tms[i] = 1'b1;
                p = 6;
`else
                p = 0;
`endif
            end
            default: p = eff;
        endcase
    endfunction

    task automatic start_cmd(input logic [1:0] op, input logic [5:0] len,
                             input logic [31:0] data, output bit ok, output int base);
        int w;
        w = 0;
        ok = 1'b0;
        base = 0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_len   = len;
        cmd_data  = data;
        while (!cmd_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (!cmd_ready) begin
            check("accept_timeout", 64'(cmd_ready), 64'd1);
            cmd_valid = 1'b0;
            return;
        end
        base = tms_log.size();
        @(posedge clk);
        #1;
        check("busy_after_accept", 64'(busy), 64'd1);
        check("ready_after_accept", 64'(cmd_ready), 64'd0);
        @(negedge clk);
        // These changes must have no effect on the command that was accepted.
        cmd_valid = 1'b0;
        cmd_op    = ~op;
        cmd_len   = ~len;
        cmd_data  = ~data;
        ok = 1'b1;
    endtask

    task automatic run_cmd(input vec_t v, input int idx);
        exp_t        e;
        bit          ok;
        int          base, n, cnt, p;
        logic [63:0] got_tms, got_tdi;
        logic [31:0] got_rsp;
        bit          stable;

        model(v.op, v.len, v.data, e.tms, e.tdi, p);
        e.rsp    = v.exp_rsp;
        e.pulses = v.exp_pulses;
        e.lat    = (v.exp_pulses == 0) ? 1 : 2 * CLK_DIV * v.exp_pulses;
        sb.push_back(e);
        tdo_mode = v.mode;

        start_cmd(v.op, v.len, v.data, ok, base);
        if (!ok) begin
            void'(sb.pop_front());
            return;
        end

        n = 0;
        while (n < 2000) begin
            @(posedge clk);
            n++;
            #1;
            if (rsp_valid) break;
        end
        got_rsp = rsp_data;
        e = sb.pop_front();
        cnt = tms_log.size() - base;
        got_tms = '0;
        got_tdi = '0;
        for (int k = 0; k < cnt && k < 64; k++) begin
            got_tms[k] = tms_log[base + k];
            got_tdi[k] = tdi_log[base + k];
        end
        $display("cmd %0d op=%0d len=%0d data=%h -> rsp=%h lat=%0d pulses=%0d",
                 idx, v.op, v.len, v.data, got_rsp, n, cnt);
        check($sformatf("rsp_data[%0d]", idx), 64'(got_rsp), 64'(e.rsp));
        check($sformatf("latency[%0d]", idx), 64'(n), 64'(e.lat));
        check($sformatf("pulses[%0d]", idx), 64'(cnt), 64'(e.pulses));
        check($sformatf("tms_seq[%0d]", idx), got_tms, e.tms);
        check($sformatf("tdi_seq[%0d]", idx), got_tdi, e.tdi);
        check($sformatf("busy_at_rsp[%0d]", idx), 64'(busy), 64'd0);

        if (v.delay > 0) begin
            stable = 1'b1;
            for (int k = 0; k < v.delay; k++) begin
                @(negedge clk);
                if (!rsp_valid || rsp_data !== got_rsp || cmd_ready !== 1'b0) stable = 1'b0;
            end
            check($sformatf("rsp_hold[%0d]", idx), 64'(stable), 64'd1);
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        check($sformatf("ready_after_rsp[%0d]", idx), 64'(cmd_ready), 64'd1);
        check($sformatf("valid_after_rsp[%0d]", idx), 64'(rsp_valid), 64'd0);
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    // ---------------- test ----------------
    initial begin
        vec_t vecs[12];
        vec_t again;
        bit   ok;
        int   base, w, seen;

`ifdef JTAG_HOST_TLR_EN
        localparam int TLR_P = 6;
`else
        localparam int TLR_P = 0;
`endif

        vecs[0]  = '{2'b00, 6'd4,  32'h0000_0007, 0, 0,  32'h0000_0007, 10};
        vecs[1]  = '{2'b01, 6'd32, 32'hA5A5_0F0F, 0, 20, 32'hA5A5_0F0F, 37};
        vecs[2]  = '{2'b01, 6'd40, 32'hFFFF_FFFF, 1, 0,  32'hFFFF_FFFF, 37};
        vecs[3]  = '{2'b01, 6'd8,  32'h0000_003C, 3, 3,  32'h0000_00C3, 13};
        vecs[4]  = '{2'b00, 6'd0,  32'h0000_0005, 0, 0,  32'h0000_0000, 0};
        vecs[5]  = '{2'b01, 6'd0,  32'h1234_5678, 1, 0,  32'h0000_0000, 0};
        vecs[6]  = '{2'b11, 6'd5,  32'hFFFF_FFFF, 1, 0,  32'h0000_0000, 5};
        vecs[7]  = '{2'b11, 6'd40, 32'h0000_0000, 1, 0,  32'h0000_0000, 32};
        vecs[8]  = '{2'b10, 6'd9,  32'hFFFF_FFFF, 1, 0,  32'h0000_0000, TLR_P};
        vecs[9]  = '{2'b01, 6'd1,  32'h0000_0001, 2, 0,  32'h0000_0000, 6};
        vecs[10] = '{2'b00, 6'd6,  32'h0000_002A, 0, 0,  32'h0000_002A, 12};
        vecs[11] = '{2'b01, 6'd31, 32'h1234_5678, 3, 0,  32'h6DCB_A987, 36};

        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_len   = 6'd0;
        cmd_data  = '0;
        rsp_ready = 1'b0;

        repeat (3) @(negedge clk);
        check("reset_tck", 64'(TCK), 64'd0);
        check("reset_tms", 64'(TMS), 64'd1);
        check("reset_tdi", 64'(TDI), 64'd0);
        check("reset_ready", 64'(cmd_ready), 64'd0);
        check("reset_valid", 64'(rsp_valid), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_rsp_data", 64'(rsp_data), 64'd0);
        rst_n = 1'b1;
        #1;
        check("ready_before_first_edge", 64'(cmd_ready), 64'd0);
        @(posedge clk);
        #1;
        check("ready_after_first_edge", 64'(cmd_ready), 64'd1);

        for (int i = 0; i < 12; i++) run_cmd(vecs[i], i);

        // Abort a 32-bit DR scan at shift bit 10. Pulses 0..2 are the head,
        // so bit 10 is pulse 13.
        tdo_mode = 0;
        start_cmd(2'b01, 6'd32, 32'hDEAD_BEEF, ok, base);
        w = 0;
        while (tms_log.size() < base + 14 && w < 2000) begin
            @(negedge clk);
            w++;
        end
        check("abort_reached_bit10", 64'(tms_log.size() >= base + 14), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        $display("abort: rst_n low at shift bit 10, TCK=%b TMS=%b", TCK, TMS);
        check("abort_tck", 64'(TCK), 64'd0);
        check("abort_tms", 64'(TMS), 64'd1);
        check("abort_tdi", 64'(TDI), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_ready", 64'(cmd_ready), 64'd0);
        check("abort_rsp_data", 64'(rsp_data), 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("abort_ready_before_edge", 64'(cmd_ready), 64'd0);
        @(posedge clk);
        #1;
        check("abort_ready_after_edge", 64'(cmd_ready), 64'd1);
        seen = 0;
        repeat (50) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        check("abort_no_rsp", 64'(seen), 64'd0);

        // A normal command after the abort.
        again = '{2'b01, 6'd16, 32'h0000_BEEF, 0, 0, 32'h0000_BEEF, 21};
        run_cmd(again, 12);

        check("tck_protocol", 64'(viol), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
